// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Build with FETCH_PREFETCH_BUF_EN defined for a two-entry prefetch buffer.
package fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

`ifdef FETCH_PREFETCH_BUF_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Depth-1/2 instruction FIFO between the fetch FSM and the decoder.
// Slot 0 is always the head, so the offered instruction comes straight from a register.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  fetch_entry_t slot0_r;
  fetch_entry_t slot1_r;
  logic [1:0]   count_r;

  fetch_entry_t slot0_nxt_s;
  fetch_entry_t slot1_nxt_s;
  logic [1:0]   count_nxt_s;
  logic         empty_s;
  logic         full_s;
  logic         pop_ok_s;
  logic         push_ok_s;

  assign empty_s   = (count_r == 2'd0);
  assign full_s    = (count_r == DEPTH_C);
  assign pop_ok_s  = pop && !empty_s;
  assign push_ok_s = push && (!full_s || pop_ok_s);

  // Next-state for the slots and occupancy count.
  always_comb begin
    slot0_nxt_s = slot0_r;
    slot1_nxt_s = slot1_r;
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            slot0_nxt_s = push_data;
          end else begin
            slot1_nxt_s = push_data;
          end
          count_nxt_s = count_r + 2'd1;
        end
        2'b01: begin
          slot0_nxt_s = slot1_r;
          count_nxt_s = count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd2) begin
            slot0_nxt_s = slot1_r;
            slot1_nxt_s = push_data;
          end else begin
            slot0_nxt_s = push_data;
          end
        end
        default: begin
          count_nxt_s = count_r;
        end
      endcase
    end
  end

  // Slot and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_r <= '0;
      slot1_r <= '0;
      count_r <= 2'd0;
    end else begin
      slot0_r <= slot0_nxt_s;
      slot1_r <= slot1_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign head  = slot0_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: one outstanding memory read, redirect/halt handling, decoder buffer.
// FETCH_PREFETCH_BUF_EN selects a two-entry buffer so fetch can run ahead of the decoder.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               halted
);

  fetch_state_e      state_r;
  fetch_state_e      state_nxt_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic              req_r;
  logic              req_nxt_s;
  logic              halt_r;
  logic              halted_r;

  logic              redirect_s;
  logic              pop_s;
  logic              push_s;
  logic              buf_full_s;
  logic              buf_empty_s;
  logic              buf_free_s;
  logic              halt_pend_s;
  fetch_entry_t      push_data_s;
  fetch_entry_t      head_s;

  // Redirects are dead once halted; a redirect also cancels any pop in that cycle.
  assign redirect_s  = redirect_valid && (state_r != HALTED);
  assign pop_s       = !buf_empty_s && instr_ready && !redirect_s;
  assign push_s      = (state_r == REQ) && imem_ack && !redirect_s;
  assign buf_free_s  = !buf_full_s || pop_s;
  assign halt_pend_s = halt_r || halt;
  assign push_data_s = {imem_rdata, pc_r};

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .flush     (redirect_s),
    .push_data (push_data_s),
    .head      (head_s),
    .full      (buf_full_s),
    .empty     (buf_empty_s)
  );

  // FSM next-state and request register next values.
  always_comb begin
    state_nxt_s = state_r;
    req_nxt_s   = req_r;
    addr_nxt_s  = addr_r;
    case (state_r)
      IDLE: begin
        if (halt_pend_s) begin
          state_nxt_s = HALTED;
        end else if (!redirect_s && buf_free_s) begin
          state_nxt_s = REQ;
          req_nxt_s   = 1'b1;
          addr_nxt_s  = pc_r;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (imem_ack) begin
          req_nxt_s   = 1'b0;
          state_nxt_s = halt_pend_s ? HALTED : IDLE;
        end else if (redirect_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = REQ;
        end
      end
      DRAIN: begin
        // The response still owed to the stale request is swallowed here.
        if (imem_ack) begin
          req_nxt_s   = 1'b0;
          state_nxt_s = halt_pend_s ? HALTED : IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      HALTED: begin
        state_nxt_s = HALTED;
        req_nxt_s   = 1'b0;
      end
      default: begin
        state_nxt_s = IDLE;
        req_nxt_s   = 1'b0;
      end
    endcase
  end

  // PC update: redirect wins over the sequential step.
  always_comb begin
    if (redirect_s) begin
      pc_nxt_s = align_word(redirect_pc);
    end else if (push_s) begin
      pc_nxt_s = pc_r + PC_STEP;
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // State, PC, halt latch and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      pc_r     <= RESET_PC;
      addr_r   <= 32'h0000_0000;
      req_r    <= 1'b0;
      halt_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      addr_r   <= addr_nxt_s;
      req_r    <= req_nxt_s;
      halt_r   <= halt_r || halt;
      halted_r <= (state_nxt_s == HALTED);
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = addr_r;
  assign halted      = halted_r;
  assign instr_valid = !buf_empty_s;
  assign instruction = head_s.instr;
  assign instr_pc    = head_s.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a random run
// scored against an in-order PC-stream model with a behavioural memory responder.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        halted;

  int checks = 0;
  int errors = 0;

  // model / responder state
  logic [31:0] exp_pc;
  int          delivered;
  int          req_cnt;
  int          mem_lat;
  int          mem_cnt;
  bit          rand_lat;
  bit          halt_model;
  bit          prev_req, prev_ack, prev_hold;
  logic [31:0] prev_addr, prev_pc, prev_instr;

  instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  task automatic reset_model();
    exp_pc = RESET_PC; mem_cnt = 0; req_cnt = 0; delivered = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_hold = 1'b0;
    prev_addr = 32'h0; prev_pc = 32'h0; prev_instr = 32'h0;
    halt_model = 1'b0; rand_lat = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    halt = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  // Negedge half: protocol checks and the memory responder.
  task automatic cyc_begin();
    @(negedge clk);
    if (prev_req && !prev_ack) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
        errors++;
        $display("FAIL req_stable: req=%0b addr=%h, required req=1 addr=%h", imem_req, imem_addr, prev_addr);
      end
    end
    if (prev_hold) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== prev_pc || instruction !== prev_instr) begin
        errors++;
        $display("FAIL hold_stable: valid=%0b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                 instr_valid, instr_pc, instruction, prev_pc, prev_instr);
      end
    end
    if (imem_req === 1'b1 && !prev_req) req_cnt++;
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    if (imem_req === 1'b1) begin
      if (mem_cnt >= mem_lat) begin
        imem_ack = 1'b1;
        imem_rdata = memfn(imem_addr);
        mem_cnt = 0;
        if (rand_lat) mem_lat = $urandom_range(0, 3);
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
  endtask

  // Drive decoder-side inputs and score any instruction accepted at the next edge.
  task automatic cyc_end(input logic rdy, input logic redir, input logic [31:0] tgt, input logic hlt);
    bit redir_eff;
    instr_ready = rdy; redirect_valid = redir; redirect_pc = tgt; halt = hlt;
    if (hlt) halt_model = 1'b1;
    redir_eff = redir && !halt_model;
    if (redir_eff) begin
      exp_pc = {tgt[31:2], 2'b00};
    end else if (instr_valid === 1'b1 && rdy) begin
      checks++;
      if (instr_pc !== exp_pc || instruction !== memfn(exp_pc)) begin
        errors++;
        $display("FAIL delivery: pc=%h instr=%h, required pc=%h instr=%h",
                 instr_pc, instruction, exp_pc, memfn(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    prev_req   = (imem_req === 1'b1);
    prev_ack   = imem_ack;
    prev_addr  = imem_addr;
    prev_hold  = (instr_valid === 1'b1) && !rdy && !redir_eff;
    prev_pc    = instr_pc;
    prev_instr = instruction;
  endtask

  task automatic cyc(input logic rdy, input logic redir, input logic [31:0] tgt, input logic hlt);
    cyc_begin();
    cyc_end(rdy, redir, tgt, hlt);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_req, instr_valid, halted} !== 3'b000 || imem_addr !== 32'h0 ||
        instruction !== 32'h0 || instr_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: req=%0b valid=%0b halted=%0b addr=%h instr=%h pc=%h, required all 0",
               imem_req, instr_valid, halted, imem_addr, instruction, instr_pc);
    end
  endtask

  task automatic test_first_fetch();
    do_reset(); mem_lat = 0;
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL first_req: req=%0b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instruction !== 32'h0000_0013) begin
      errors++; $display("FAIL first_instr: valid=%0b pc=%h instr=%h, required 1 00000000 00000013",
                         instr_valid, instr_pc, instruction);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++; $display("FAIL second_req: req=%0b addr=%h, required 1 00000004", imem_req, imem_addr);
    end
  endtask

  task automatic test_backpressure();
    logic        exp_valid;
    logic [31:0] exp_addr;
    do_reset(); mem_lat = 0;
    repeat (8) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (req_cnt != BUF_DEPTH || instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL backpressure_fill: reqs=%0d valid=%0b pc=%h req=%0b, required reqs=%0d 1 0 0",
                         req_cnt, instr_valid, instr_pc, imem_req, BUF_DEPTH);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    exp_valid = (BUF_DEPTH == 2);
    exp_addr  = 32'(BUF_DEPTH * 4);
    checks++;
    if (instr_valid !== exp_valid || imem_req !== 1'b1 || imem_addr !== exp_addr ||
        (exp_valid && instr_pc !== 32'h4)) begin
      errors++; $display("FAIL backpressure_pop: valid=%0b pc=%h req=%0b addr=%h, required valid=%0b req=1 addr=%h",
                         instr_valid, instr_pc, imem_req, imem_addr, exp_valid, exp_addr);
    end
  endtask

  task automatic test_redirect_drain();
    bit hit;
    do_reset(); mem_lat = 4; hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      cyc_begin();
      hit = (imem_req === 1'b1 && imem_addr === 32'h8);
      cyc_end(1'b1, 1'b0, 32'h0, 1'b0);
    end
    cyc(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc_begin();
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++; $display("FAIL drain_valid: valid=%0b pc=%h, required 0", instr_valid, instr_pc);
      end
      if (imem_req === 1'b1 && imem_addr !== 32'h8) begin
        hit = 1'b1;
        checks++;
        if (imem_addr !== 32'h100) begin
          errors++; $display("FAIL drain_next_req: addr=%h, required 00000100", imem_addr);
        end
      end
      cyc_end(1'b1, 1'b0, 32'h0, 1'b0);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL drain_timeout: no request after drain, required one"); end
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc_begin();
      if (instr_valid === 1'b1) begin
        hit = 1'b1;
        checks++;
        if (instr_pc !== 32'h100) begin
          errors++; $display("FAIL drain_deliver: pc=%h, required 00000100", instr_pc);
        end
      end
      cyc_end(1'b1, 1'b0, 32'h0, 1'b0);
    end
  endtask

  task automatic test_redirect_ack();
    bit hit;
    do_reset(); mem_lat = 1; hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cyc_begin();
      hit = (imem_ack && imem_addr === 32'h4);
      cyc_end(1'b1, hit, 32'h0000_0204, 1'b0);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL redir_ack_setup: no ack for 00000004 seen, required one"); end
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc_begin();
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++; $display("FAIL redir_ack_valid: valid=%0b pc=%h, required 0", instr_valid, instr_pc);
      end
      if (imem_req === 1'b1) begin
        hit = 1'b1;
        checks++;
        if (imem_addr !== 32'h204) begin
          errors++; $display("FAIL redir_ack_req: addr=%h, required 00000204", imem_addr);
        end
      end
      cyc_end(1'b1, 1'b0, 32'h0, 1'b0);
    end
  endtask

  task automatic test_wrap();
    do_reset(); mem_lat = 0;
    cyc(1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0);
    delivered = 0;
    repeat (20) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (delivered < 3) begin
      errors++; $display("FAIL wrap_progress: delivered=%0d, required >=3", delivered);
    end
  endtask

  task automatic test_halt();
    bit acked;
    do_reset(); mem_lat = 2; acked = 1'b0;
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL halt_setup: req=%0b, required 1", imem_req); end
    for (int i = 0; i < 10 && !acked; i++) begin
      cyc_begin();
      acked = imem_ack;
      cyc_end(1'b1, 1'b0, 32'h0, 1'b0);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL halt_enter: halted=%0b valid=%0b pc=%h req=%0b, required 1 1 00000000 0",
                         halted, instr_valid, instr_pc, imem_req);
    end
    cyc(1'b1, 1'b1, 32'h0000_0300, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL halt_stay: halted=%0b req=%0b valid=%0b, required 1 0 0",
                           halted, imem_req, instr_valid);
      end
    end
    checks++;
    if (delivered != 1) begin errors++; $display("FAIL halt_delivered: %0d, required 1", delivered); end
  endtask

  task automatic test_reset_mid();
    do_reset(); mem_lat = 10;
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rstmid_setup: req=%0b, required 1", imem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, instr_valid, halted} !== 3'b000 || imem_addr !== 32'h0 ||
        instruction !== 32'h0 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL rstmid_outputs: req=%0b valid=%0b halted=%0b addr=%h, required all 0",
                         imem_req, instr_valid, halted, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    mem_lat = 0;
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL rstmid_req: req=%0b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC);
    end
    repeat (6) cyc(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    logic        rdy, redir;
    logic [31:0] tgt;
    do_reset(); rand_lat = 1'b1; mem_lat = $urandom_range(0, 3);
    for (int i = 0; i < 1500; i++) begin
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 29) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cyc(rdy, redir, tgt, 1'b0);
    end
    rand_lat = 1'b0;
    checks++;
    if (delivered < 50) begin
      errors++; $display("FAIL random_progress: delivered=%0d, required >=50", delivered);
    end
  endtask

  initial begin
    reset_model();
    mem_lat = 0;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have one clock, clk; reset SHALL be asynchronous and active-low, rst_n.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 imem_req  output  1  instruction-memory read request, registered.
REQ-006 imem_addr  output  32  word address of the request, registered.
REQ-007 imem_ack  input  1  memory response strobe, one cycle.
REQ-008 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-009 instr_valid  output  1  instruction offered to decoder.
REQ-010 instr_ready  input  1  decoder accepts the offered instruction.
REQ-011 instruction  output  32  instruction word to decoder.
REQ-012 instr_pc  output  32  PC of the offered instruction.
REQ-013 redirect_valid  input  1  branch/jump redirect strobe.
REQ-014 redirect_pc  input  32  redirect target.
REQ-015 halt  input  1  stop request from decoder; sticky until reset.
REQ-016 halted  output  1  fetch stopped, no request outstanding.

Function
REQ-017 FSM states: IDLE, REQ, DRAIN, HALTED; at most one memory request outstanding.
REQ-018 IDLE->REQ when buffer has a free entry and halt latch clear; imem_req=1 and imem_addr=pc from the next cycle.
REQ-019 In REQ, imem_req and imem_addr SHALL hold stable until imem_ack.
REQ-020 REQ with imem_ack and no redirect: push {imem_rdata, pc} into buffer, pc<=pc+4 (modulo 2^32), go IDLE; instr_valid visible the following cycle.
REQ-021 redirect_valid (any state except HALTED): flush buffer, pc<=redirect_pc with bits[1:0] forced 0.
REQ-022 Redirect in REQ without imem_ack: go DRAIN; discard the response on its ack, then IDLE.
REQ-023 Redirect in REQ coincident with imem_ack: discard that data, go IDLE directly.
REQ-024 Redirect coincident with a pop: pop suppressed; buffer empty next cycle.
REQ-025 halt latched on assertion; in-flight request completes and its data is buffered; then HALTED; halted=1 only in HALTED.
REQ-026 In HALTED no requests issue, redirects are ignored, buffered instructions remain deliverable.
REQ-027 instr_valid=1 iff buffer non-empty; pop on instr_valid && instr_ready; instruction/instr_pc SHALL be stable while valid && !ready.
REQ-028 imem_ack outside REQ/DRAIN SHALL be ignored.

Reset
REQ-029 On rst_n low: pc=RESET_PC, state IDLE, buffer empty, halt latch clear, imem_req=0, imem_addr=0, instr_valid=0, instruction=0, instr_pc=0, halted=0.
REQ-030 Reset asserted mid-request SHALL abandon it; no response is expected after reset release.

Configuration
REQ-031 Macro FETCH_PREFETCH_BUF_EN defined: buffer depth 2, next request may issue while one instruction waits for the decoder.
REQ-032 Macro undefined: buffer depth 1; a new request issues only once the buffer is empty or being popped that cycle.

Structure
REQ-033 Package fetch_pkg SHALL hold the FSM state enum, ADDR_W=32, INSTR_W=32, PC_STEP=4, buffer depth constant.
REQ-034 Sub-module fetch_buffer SHALL implement the depth-1/2 FIFO with push, pop, flush, full, empty.

Verification
REQ-035 Reset release, memory acks 1 cycle after req with 0x00000013 -> first request addr 0x0, instr_valid with instr_pc=0x0, next request addr 0x4.
REQ-036 instr_ready held 0, macro defined -> exactly two instructions buffered (pc 0x0, 0x4), imem_req stays 0 until a pop.
REQ-037 Redirect to 0x103 while request to 0x8 outstanding, ack 3 cycles later -> data from 0x8 discarded, next request addr 0x100, instr_valid=0 meanwhile.
REQ-038 Redirect coincident with imem_ack -> acked data not delivered; next request addr = redirect target.
REQ-039 halt asserted during REQ -> acked word delivered, halted=1 the cycle after ack, no further imem_req; later redirect ignored.
REQ-040 rst_n pulsed low mid-REQ -> all outputs 0 immediately; after release, first request addr RESET_PC.
